// File: rtl/arrow_sequencer_pkg.sv
// arrow_sequencer_pkg
// Shared definitions for the arrow pipeline: game state codes, arrow codes,
// their widths, and the pattern-LFSR helpers used by arrow_sequencer.
// No ports.
package arrow_sequencer_pkg;

  localparam int STATE_BITS      = 1;
  localparam int NUM_ARROWS_BITS = 2;

  typedef enum logic [STATE_BITS:0] {
    STATE_RESET = 2'd0,
    STATE_GAME  = 2'd1,
    STATE_PAUSE = 2'd2,
    STATE_END   = 2'd3
  } state_e;

  typedef logic [NUM_ARROWS_BITS:0] arrow_t;

  localparam arrow_t ARROW_NONE  = 3'd0;
  localparam arrow_t ARROW_LEFT  = 3'd1;
  localparam arrow_t ARROW_DOWN  = 3'd2;
  localparam arrow_t ARROW_UP    = 3'd3;
  localparam arrow_t ARROW_RIGHT = 3'd4;

  // Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16).
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Bits [3:2] == 0 give a rest; otherwise bits [1:0] pick the direction.
  function automatic arrow_t lfsr_to_arrow(input logic [15:0] l);
    arrow_t a;
    if (l[3:2] == 2'b00) a = ARROW_NONE;
    else                 a = arrow_t'({1'b0, l[1:0]}) + ARROW_LEFT;
    return a;
  endfunction

endpackage

// File: rtl/arrow_sequencer_rom.sv
// arrow_rom
// Combinational song ROM: beat index -> arrow code. Indices at or beyond
// DEPTH read as ARROW_NONE. Only compiled when ARROW_SEQ_ROM_EN is defined.
// Ports:
//   idx_i   [7:0]  beat index (arrow loads performed so far)
//   arrow_o [2:0]  arrow code for that beat
`ifdef ARROW_SEQ_ROM_EN
module arrow_rom
  import arrow_sequencer_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic [7:0] idx_i,
  output arrow_t     arrow_o
);

  always_comb begin
    arrow_o = ARROW_NONE;
    if ({24'd0, idx_i} < DEPTH) begin
      case (idx_i[2:0])
        3'd0:    arrow_o = ARROW_LEFT;
        3'd1:    arrow_o = ARROW_DOWN;
        3'd2:    arrow_o = ARROW_NONE;
        3'd3:    arrow_o = ARROW_UP;
        3'd4:    arrow_o = ARROW_RIGHT;
        3'd5:    arrow_o = ARROW_LEFT;
        3'd6:    arrow_o = ARROW_NONE;
        default: arrow_o = ARROW_DOWN;
      endcase
    end
  end

endmodule
`endif

// File: rtl/arrow_sequencer.sv
// arrow_sequencer
// Game-flow controller for the arrow pipeline: owns the game state, makes
// the metronome beat and presents the next arrow code half a beat before
// each metronome rising edge.
// Configuration macro: ARROW_SEQ_ROM_EN -- when defined, pattern arrows come
// from arrow_rom indexed by beat_cnt and no LFSR is built; otherwise a
// 16-bit LFSR seeded with LFSR_SEED generates the pattern.
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   start          one-cycle pulse: RESET->GAME, END->RESET
//   pause          one-cycle pulse: toggles GAME<->PAUSE
//   state          game state code
//   metronome_clk  beat square wave, high for the first half of each beat
//   next_arrow     arrow code to shift in at the next rising edge
//   beat_cnt       arrow loads performed this run
module arrow_sequencer
  import arrow_sequencer_pkg::*;
#(
  parameter int          BEAT_DIV   = 50_000_000,
  parameter int          SONG_BEATS = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pause,
  output logic [STATE_BITS:0]      state,
  output logic                     metronome_clk,
  output logic [NUM_ARROWS_BITS:0] next_arrow,
  output logic [7:0]               beat_cnt
);

  localparam int PH_W = $clog2(BEAT_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BEAT_DIV - 1);
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(BEAT_DIV / 2 - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(BEAT_DIV / 2);

  state_e          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            metro_q, metro_d;
  arrow_t          arrow_q, arrow_d;
  logic [7:0]      beat_q, beat_d;
  arrow_t          pattern;

`ifdef ARROW_SEQ_ROM_EN
  arrow_rom #(.DEPTH(SONG_BEATS)) u_rom (
    .idx_i   (beat_q),
    .arrow_o (pattern)
  );
`else
  logic [15:0] lfsr_q, lfsr_d;
  assign pattern = lfsr_to_arrow(lfsr_q);
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    arrow_d = arrow_q;
    beat_d  = beat_q;
`ifndef ARROW_SEQ_ROM_EN
    lfsr_d  = lfsr_q;
`endif
    unique case (state_q)
      STATE_RESET: begin
        ph_d    = '0;
        arrow_d = ARROW_NONE;
        beat_d  = '0;
`ifndef ARROW_SEQ_ROM_EN
        lfsr_d  = LFSR_SEED;
`endif
        if (start) state_d = STATE_GAME;
      end
      STATE_GAME: begin
        // The cycle a pause is taken is treated as already paused: ph does
        // not advance and no load fires, so resuming replays it exactly.
        if (pause) begin
          state_d = STATE_PAUSE;
        end else begin
          ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
          if (ph_q == PH_LOAD) begin
            if ({24'd0, beat_q} < SONG_BEATS) begin
              arrow_d = pattern;
              beat_d  = beat_q + 8'd1;
`ifndef ARROW_SEQ_ROM_EN
              lfsr_d  = lfsr_step(lfsr_q);
`endif
            end else if ({24'd0, beat_q} < SONG_BEATS + 4) begin
              // Four trailing rests drain the downstream four-deep buffer.
              arrow_d = ARROW_NONE;
              beat_d  = beat_q + 8'd1;
            end else begin
              state_d = STATE_END;
              arrow_d = ARROW_NONE;
            end
          end
        end
      end
      STATE_PAUSE: begin
        if (pause) state_d = STATE_GAME;
      end
      default: begin
        arrow_d = ARROW_NONE;
        if (start) state_d = STATE_RESET;
      end
    endcase

    // Registered metronome: computed from next-state so it rises together
    // with the first GAME cycle and stays frozen while paused.
    if (state_d == STATE_GAME)       metro_d = (ph_d < PH_HALF);
    else if (state_d == STATE_PAUSE) metro_d = metro_q;
    else                             metro_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_RESET;
      ph_q    <= '0;
      metro_q <= 1'b0;
      arrow_q <= ARROW_NONE;
      beat_q  <= '0;
`ifndef ARROW_SEQ_ROM_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      metro_q <= metro_d;
      arrow_q <= arrow_d;
      beat_q  <= beat_d;
`ifndef ARROW_SEQ_ROM_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign state         = state_q;
  assign metronome_clk = metro_q;
  assign next_arrow    = arrow_q;
  assign beat_cnt      = beat_q;

endmodule

// File: tb/tb_arrow_sequencer.sv
// Testbench for arrow_sequencer (BEAT_DIV=8, SONG_BEATS=4, default seed).
module tb_arrow_sequencer;

  localparam int BD   = 8;
  localparam int SB   = 4;
  localparam int HALF = BD / 2;
  localparam int S_RESET = 0, S_GAME = 1, S_PAUSE = 2, S_END = 3;
  localparam int END_STEPS = SB * BD + 4 * BD + HALF; // game cycles to END

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause;
  logic [1:0] state;
  logic       metronome_clk;
  logic [2:0] next_arrow;
  logic [7:0] beat_cnt;

  arrow_sequencer #(.BEAT_DIV(BD), .SONG_BEATS(SB), .LFSR_SEED(16'hACE1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pause         (pause),
    .state         (state),
    .metronome_clk (metronome_clk),
    .next_arrow    (next_arrow),
    .beat_cnt      (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: song pattern derived from the LFSR rules, game
  // timeline tracked as phase within beat and loads performed.
  int pat [SB];
  int m_st, m_ph, m_beat, m_arrow, m_metro;
  int prev_beat;

  function automatic int map_arrow(input int l);
    if (((l >> 2) & 3) == 0) return 0;
    return (l & 3) + 1;
  endfunction

  task automatic build_pattern();
    int l;
    l = 'hACE1;
    for (int i = 0; i < SB; i++) begin
      pat[i] = map_arrow(l);
      l = ((l << 1) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1)) & 'hFFFF;
    end
  endtask

  function automatic int expected_load(input int idx);
    return (idx < SB) ? pat[idx] : 0;
  endfunction

  task automatic model_reset();
    m_st = S_RESET; m_ph = 0; m_beat = 0; m_arrow = 0; m_metro = 0;
    prev_beat = 0;
  endtask

  task automatic model_step(input bit s, input bit p);
    case (m_st)
      S_RESET: begin
        m_ph = 0; m_beat = 0; m_arrow = 0;
        if (s) m_st = S_GAME;
      end
      S_GAME: begin
        if (p) m_st = S_PAUSE;
        else begin
          if (m_ph == HALF - 1) begin
            if (m_beat < SB + 4) begin
              m_arrow = expected_load(m_beat);
              m_beat++;
            end else begin
              m_st = S_END;
              m_arrow = 0;
            end
          end
          m_ph = (m_ph + 1) % BD;
        end
      end
      S_PAUSE: if (p) m_st = S_GAME;
      default: begin
        m_arrow = 0;
        if (s) m_st = S_RESET;
      end
    endcase
    if (m_st == S_GAME)       m_metro = (m_ph < HALF) ? 1 : 0;
    else if (m_st != S_PAUSE) m_metro = 0;
  endtask

  task automatic compare_outputs();
    check("state", int'(state), m_st);
    check("metronome", int'(metronome_clk), m_metro);
    check("next_arrow", int'(next_arrow), m_arrow);
    check("beat_cnt", int'(beat_cnt), m_beat);
    if (int'(beat_cnt) != prev_beat && beat_cnt != 8'd0)
      check("load_value", int'(next_arrow), expected_load(int'(beat_cnt) - 1));
    prev_beat = int'(beat_cnt);
  endtask

  task automatic step(input bit s, input bit p);
    start = s; pause = p;
    @(posedge clk);
    model_step(s, p);
    #1;
    start = 1'b0; pause = 1'b0;
    compare_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, int'(state), S_RESET);
    check({tag, "_metro"}, int'(metronome_clk), 0);
    check({tag, "_arrow"}, int'(next_arrow), 0);
    check({tag, "_beat"}, int'(beat_cnt), 0);
  endtask

  int n;

  initial begin
    build_pattern();
    rst_n = 1'b0; start = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;

    // Idle in RESET without start.
    repeat (20) step(1'b0, 1'b0);
    check_reset_values("idle");

    // Full run with stray start pulses during GAME (ignored).
    step(1'b1, 1'b0);
    check("enter_game", int'(state), S_GAME);
    check("first_metro", int'(metronome_clk), 1);
    n = 0;
    while (state != 2'(S_END) && n < 200) begin
      step(($urandom % 4) == 0, 1'b0);
      n++;
    end
    check("end_time", n, END_STEPS);
    check("end_beat_cnt", int'(beat_cnt), SB + 4);
    check("end_metro", int'(metronome_clk), 0);

    // END -> RESET, then start+pause together in RESET -> GAME.
    step(1'b1, 1'b0);
    check("end_to_reset", int'(state), S_RESET);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("start_wins", int'(state), S_GAME);

    // Pause at ph=2 of beat 2, resume 20 cycles later.
    n = 0;
    repeat (BD + 2) begin step(1'b0, 1'b0); n++; end
    step(1'b0, 1'b1); n++;
    check("paused", int'(state), S_PAUSE);
    repeat (19) begin step(1'b0, 1'b0); n++; end
    step(1'b0, 1'b1); n++;
    check("resumed", int'(state), S_GAME);
    while (state != 2'(S_END) && n < 300) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("end_time_paused", n, END_STEPS + 21);

    // Asynchronous reset mid-beat, then replay.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (13) step(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("async_hold");
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n = 0;
    while (state != 2'(S_END) && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("end_time_replay", n, END_STEPS);

    // Randomized pulses across several runs.
    for (int i = 0; i < 800; i++)
      step(($urandom % 24) == 0, ($urandom % 12) == 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
